// File: rtl/handshake_receiver.sv
// Valid/busy receiver feeding a first-word-fall-through buffer.
// A word offered while full is dropped and latches a sticky overflow.
module handshake_receiver #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       valid_in,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       busy,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_out_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Backpressure comes from occupancy alone, never from the pop request.
  assign busy           = (count == FULL);
  assign data_out_valid = (count != '0);
  assign data_out       = mem[rd_ptr];
  assign push           = valid_in && !busy;
  assign pop            = rd_en && data_out_valid;

  // Storage needs no reset; only occupied slots are ever observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy tracks the net effect of push and pop this edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Any word offered while full is lost; remember it until reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (valid_in && busy) begin
      overflow <= 1'b1;
    end
  end

endmodule
